// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths,
// the NOP encoding and the loader FSM states.
package cpu_pkg;

  localparam int INSTR_W_DEF = 18;
  localparam int ADDR_W_DEF  = 16;

  // Widest instruction the loader can assemble
  localparam int INSTR_W_MAX = 24;

  // NOP is the all-zero instruction word
  localparam logic [INSTR_W_MAX-1:0] NOP_WORD = '0;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } ld_state_e;

endpackage

// File: rtl/progmem_array.sv
// Single-port instruction store with a
// registered read port and synchronous write.
module progmem_array #(
  parameter int W     = 18,
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic          i_re,
  input  logic [AW-1:0] i_addr,
  input  logic [W-1:0]  i_wdata,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] rdata_q;

  // Contents survive reset; read data holds
  // between reads
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem[i_addr] <= i_wdata;
    end
    if (i_re) begin
      rdata_q <= mem[i_addr];
    end
  end

  assign o_rdata = rdata_q;

endmodule

// File: rtl/progmem_loader.sv
// Writable program memory: one-cycle fetch port
// plus a big-endian 3-byte-per-word loader.
module progmem_loader
  import cpu_pkg::*;
#(
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DEPTH   = 64,
  parameter int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_fetch_valid,
  input  logic [ADDR_W-1:0]  i_addr,
  output logic [INSTR_W-1:0] o_instr,
  output logic               o_instr_valid,
  output logic               o_addr_err,
  input  logic               i_load_start,
  input  logic [CNT_W-1:0]   i_load_len,
  input  logic               i_load_valid,
  input  logic [7:0]         i_load_byte,
  output logic               o_load_ready,
  output logic               o_busy,
  output logic               o_load_done,
  output logic               o_load_err
);

  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int HI_W = INSTR_W - 16;

  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

  ld_state_e        state_q, state_d;
  logic [CNT_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [1:0]       phase_q, phase_d;
  logic [HI_W-1:0]  hi_q, hi_d;
  logic [7:0]       mid_q, mid_d;
  logic             err_q, err_d;
  logic             valid_q, valid_d;
  logic             nop_q, nop_d;

  logic               busy;
  logic               fetch_acc;
  logic               in_rng;
  logic               mem_we;
  logic               mem_re;
  logic [AW-1:0]      mem_addr;
  logic [INSTR_W-1:0] mem_wdata;
  logic [INSTR_W-1:0] mem_rdata;

  assign busy      = (state_q != IDLE);
  assign fetch_acc = i_fetch_valid & ~busy;
  assign in_rng    = (i_addr < DEPTH_A);
  assign mem_re    = fetch_acc & in_rng;
  assign mem_addr  = busy ? ptr_q[AW-1:0]
                          : i_addr[AW-1:0];
  assign mem_wdata = {hi_q, mid_q, i_load_byte};

  // Loader FSM, byte assembly and fetch tracking
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    phase_d = phase_q;
    hi_d    = hi_q;
    mid_d   = mid_q;
    err_d   = err_q;
    mem_we  = 1'b0;
    valid_d = fetch_acc;
    nop_d   = nop_q;
    if (fetch_acc) begin
      nop_d = ~in_rng;
    end
    unique case (state_q)
      IDLE: begin
        if (i_load_start) begin
          ptr_d   = '0;
          phase_d = '0;
          rem_d   = i_load_len;
          err_d   = (i_load_len > DEPTH_C);
          state_d = (i_load_len != '0) ? LOAD
                                       : DONE;
        end
      end
      LOAD: begin
        if (i_load_valid) begin
          unique case (phase_q)
            2'd0: begin
              hi_d    = i_load_byte[HI_W-1:0];
              phase_d = 2'd1;
            end
            2'd1: begin
              mid_d   = i_load_byte;
              phase_d = 2'd2;
            end
            default: begin
              phase_d = 2'd0;
              mem_we  = (ptr_q < DEPTH_C);
              ptr_d   = ptr_q + CNT_W'(1);
              rem_d   = rem_q - CNT_W'(1);
              if (rem_q == CNT_W'(1)) begin
                state_d = DONE;
              end
            end
          endcase
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; memory is untouched by reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
      phase_q <= '0;
      hi_q    <= '0;
      mid_q   <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      nop_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      phase_q <= phase_d;
      hi_q    <= hi_d;
      mid_q   <= mid_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      nop_q   <= nop_d;
    end
  end

  progmem_array #(
    .W     (INSTR_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .i_clk   (i_clk),
    .i_we    (mem_we),
    .i_re    (mem_re),
    .i_addr  (mem_addr),
    .i_wdata (mem_wdata),
    .o_rdata (mem_rdata)
  );

  assign o_instr       = nop_q ? NOP_WORD[INSTR_W-1:0]
                               : mem_rdata;
  assign o_instr_valid = valid_q;
  assign o_addr_err    = valid_q & nop_q;
  assign o_load_ready  = (state_q == LOAD);
  assign o_busy        = busy;
  assign o_load_done   = (state_q == DONE);
  assign o_load_err    = err_q;

endmodule

// File: tb/tb_progmem_loader.sv
// Scoreboard bench for progmem_loader: loads,
// fetches, load errors, gaps and mid-load reset.
module tb_progmem_loader;

  localparam int IW    = 18;
  localparam int AW    = 16;
  localparam int DEPTH = 64;
  localparam int CW    = 7;

  logic          clk = 1'b0;
  logic          i_rst;
  logic          i_fetch_valid;
  logic [AW-1:0] i_addr;
  logic [IW-1:0] o_instr;
  logic          o_instr_valid;
  logic          o_addr_err;
  logic          i_load_start;
  logic [CW-1:0] i_load_len;
  logic          i_load_valid;
  logic [7:0]    i_load_byte;
  logic          o_load_ready;
  logic          o_busy;
  logic          o_load_done;
  logic          o_load_err;

  always #5 clk = ~clk;

  progmem_loader #(
    .INSTR_W (IW),
    .ADDR_W  (AW),
    .DEPTH   (DEPTH),
    .CNT_W   (CW)
  ) dut (
    .i_clk         (clk),
    .i_rst         (i_rst),
    .i_fetch_valid (i_fetch_valid),
    .i_addr        (i_addr),
    .o_instr       (o_instr),
    .o_instr_valid (o_instr_valid),
    .o_addr_err    (o_addr_err),
    .i_load_start  (i_load_start),
    .i_load_len    (i_load_len),
    .i_load_valid  (i_load_valid),
    .i_load_byte   (i_load_byte),
    .o_load_ready  (o_load_ready),
    .o_busy        (o_busy),
    .o_load_done   (o_load_done),
    .o_load_err    (o_load_err)
  );

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;
  int acc_cnt  = 0;
  int d0;

  logic [IW:0]   exp_q [$];
  logic [IW:0]   mon_e;
  logic [IW-1:0] ref_mem [DEPTH];
  logic [IW-1:0] old1;

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] ex);
    checks++;
    if (got !== ex) begin
      errors++;
      $display("FAIL %s got %h expected %h",
               nm, got, ex);
    end
  endtask

  // Response monitor: pops one expectation
  // per valid fetch response
  always @(negedge clk) begin
    if (o_load_done) done_cnt++;
    if (o_instr_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL fetch_unexpected got %h err %b",
                 o_instr, o_addr_err);
      end else begin
        mon_e = exp_q.pop_front();
        if ({o_addr_err, o_instr} !== mon_e) begin
          errors++;
          $display("FAIL fetch got %h expected %h",
                   {o_addr_err, o_instr}, mon_e);
        end
      end
    end
  end

  function automatic logic [IW-1:0] pat(int i);
    return IW'(i * 46037 + 4660);
  endfunction

  task automatic fetch(input int a);
    if (a < DEPTH) exp_q.push_back({1'b0, ref_mem[a]});
    else exp_q.push_back({1'b1, {IW{1'b0}}});
    i_fetch_valid = 1'b1;
    i_addr = AW'(a);
    @(posedge clk); #1;
    i_fetch_valid = 1'b0;
  endtask

  task automatic start_load(input int len);
    i_load_start = 1'b1;
    i_load_len = CW'(len);
    @(posedge clk); #1;
    i_load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int  n;
    bit  acc;
    n = 0;
    i_load_valid = 1'b1;
    i_load_byte = b;
    forever begin
      @(negedge clk);
      acc = o_load_ready;
      @(posedge clk); #1;
      if (acc) begin
        acc_cnt++;
        break;
      end
      n++;
      if (n > 50) begin
        chk("byte_timeout", 0, 1);
        break;
      end
    end
    i_load_valid = 1'b0;
  endtask

  // A gap cycle also issues a fetch that the
  // busy loader must drop
  task automatic gap();
    i_load_valid = 1'b0;
    i_fetch_valid = 1'b1;
    i_addr = '0;
    @(posedge clk); #1;
    i_fetch_valid = 1'b0;
  endtask

  task automatic send_word(input logic [IW-1:0] w,
                           input logic [7:0] pad,
                           input bit gaps);
    if (gaps) gap();
    send_byte({pad[7:2], w[17:16]});
    if (gaps) gap();
    send_byte(w[15:8]);
    if (gaps) gap();
    send_byte(w[7:0]);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (o_busy && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle_timeout", 32'(n < 40), 1);
  endtask

  logic [IW-1:0] gw [3];

  initial begin
    i_rst = 1'b1;
    i_fetch_valid = 1'b0;
    i_addr = '0;
    i_load_start = 1'b0;
    i_load_len = '0;
    i_load_valid = 1'b0;
    i_load_byte = '0;
    repeat (3) @(posedge clk);
    #1 i_rst = 1'b0;
    @(negedge clk);
    chk("reset_outputs",
        {o_instr, o_instr_valid, o_addr_err,
         o_load_ready, o_busy, o_load_done,
         o_load_err}, 0);
    @(posedge clk); #1;

    // Overlong load: 66 words, 64 kept
    d0 = done_cnt;
    acc_cnt = 0;
    start_load(66);
    chk("len_err_set", o_load_err, 1);
    chk("ready_in_load", o_load_ready, 1);
    for (int i = 0; i < 66; i++) begin
      if (i < DEPTH) ref_mem[i] = pat(i);
      send_word(pat(i), 8'hA8, 1'b0);
    end
    wait_idle();
    repeat (2) @(posedge clk); #1;
    chk("bytes_accepted_66", acc_cnt, 198);
    chk("done_once_66", done_cnt - d0, 1);
    chk("len_err_sticky", o_load_err, 1);
    fetch(63);
    fetch(0);
    fetch(1);
    fetch(64);
    fetch(65);

    // Two-word load, back-to-back fetch
    d0 = done_cnt;
    start_load(2);
    chk("len_err_clear", o_load_err, 0);
    ref_mem[0] = 18'h01010;
    ref_mem[1] = 18'h3C000;
    send_word(ref_mem[0], 8'h00, 1'b0);
    send_word(ref_mem[1], 8'h00, 1'b0);
    wait_idle();
    fetch(0);
    fetch(1);
    repeat (2) @(posedge clk); #1;
    chk("done_once_2", done_cnt - d0, 1);

    // Three words with valid toggling
    gw[0] = 18'h2ABCD;
    gw[1] = 18'h15555;
    gw[2] = 18'h00F0F;
    d0 = done_cnt;
    acc_cnt = 0;
    start_load(3);
    for (int i = 0; i < 3; i++) begin
      ref_mem[i] = gw[i];
      send_word(gw[i], 8'h00, 1'b1);
    end
    wait_idle();
    chk("bytes_accepted_3", acc_cnt, 9);
    fetch(0);
    fetch(1);
    fetch(2);
    fetch(3);
    repeat (2) @(posedge clk); #1;
    chk("done_once_3", done_cnt - d0, 1);

    // Reset after 4 bytes; start with fetch
    old1 = ref_mem[1];
    d0 = done_cnt;
    exp_q.push_back({1'b0, ref_mem[1]});
    i_fetch_valid = 1'b1;
    i_addr = AW'(1);
    start_load(2);
    i_fetch_valid = 1'b0;
    send_word(18'h3FFFF, 8'h00, 1'b0);
    send_byte(8'h01);
    ref_mem[0] = 18'h3FFFF;
    i_rst = 1'b1;
    @(posedge clk); #1;
    i_rst = 1'b0;
    chk("rst_mid_idle",
        {o_busy, o_load_ready, o_load_done}, 0);
    repeat (3) @(posedge clk); #1;
    chk("rst_mid_no_done", done_cnt - d0, 0);
    fetch(0);
    fetch(1);
    @(posedge clk); #1;
    chk("rst_mid_word1_kept", ref_mem[1], old1);

    // Zero-length load
    d0 = done_cnt;
    start_load(0);
    chk("len0_done_busy",
        {o_busy, o_load_done, o_load_ready}, 3'b110);
    @(posedge clk); #1;
    chk("len0_idle_after",
        {o_busy, o_load_done}, 0);
    chk("len0_err", o_load_err, 0);
    fetch(0);
    fetch(1);
    fetch(2);
    repeat (3) @(posedge clk); #1;
    chk("len0_done_once", done_cnt - d0, 1);
    chk("queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
